// File: rtl/dmem_sync_hs.sv
// dmem_sync_hs: single-port data memory with valid/ready request and response channels,
// 1- or 2-cycle read pipeline. Define DMEM_PARITY_EN to add per-word even parity.
module dmem_sync_hs #(
   parameter int unsigned       DATA_W    = 16,
   parameter int unsigned       ADDR_W    = 8,
   parameter int unsigned       DEPTH     = 8,
   parameter int unsigned       RD_LAT    = 1,
   parameter logic [DATA_W-1:0] INIT_WORD = 16'hFFFF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                rsp_perr
);
   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] r_mem [DEPTH] = '{default: INIT_WORD};
`ifdef DMEM_PARITY_EN
   logic              r_par [DEPTH] = '{default: ^INIT_WORD};
`endif

   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              r_rsp_err;
   logic              r_rsp_perr;

   logic              w_stall;
   logic              w_acc;
   logic              w_rd_acc;
   logic              w_in_range;
   logic [IDX_W-1:0]  w_idx;
   logic [DATA_W-1:0] w_rd_word;
   logic [DATA_W-1:0] w_merged;
   logic [DATA_W-1:0] w_s_data;
   logic              w_s_err;
   logic              w_s_perr;
   logic              w_o_valid;
   logic [DATA_W-1:0] w_o_data;
   logic              w_o_err;
   logic              w_o_perr;

   assign w_stall    = r_rsp_valid & ~rsp_ready;
   assign req_ready  = ~w_stall;
   assign w_acc      = req_valid & ~w_stall;
   assign w_rd_acc   = w_acc & ~req_we;
   // Full address is range-checked so upper bits never alias onto implemented words
   assign w_in_range = (32'(req_addr) < DEPTH);
   assign w_idx      = req_addr[IDX_W-1:0];

   always_comb begin
      w_rd_word = r_mem[w_idx];
      w_merged  = w_rd_word;
      for (int i = 0; i < BE_W; i++) begin
         if (req_be[i]) w_merged[8*i +: 8] = req_wdata[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (w_acc && req_we && w_in_range) begin
         r_mem[w_idx] <= w_merged;
`ifdef DMEM_PARITY_EN
         r_par[w_idx] <= ^w_merged;
`endif
      end
   end

   always_comb begin
      w_s_data = '0;
      w_s_err  = 1'b1;
      w_s_perr = 1'b0;
      if (w_in_range) begin
         w_s_data = w_rd_word;
         w_s_err  = 1'b0;
`ifdef DMEM_PARITY_EN
         w_s_perr = (^w_rd_word) ^ r_par[w_idx];
`endif
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic              r_s1_valid;
         logic [DATA_W-1:0] r_s1_data;
         logic              r_s1_err;
         logic              r_s1_perr;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_s1_valid <= 1'b0;
               r_s1_data  <= '0;
               r_s1_err   <= 1'b0;
               r_s1_perr  <= 1'b0;
            end else if (!w_stall) begin
               r_s1_valid <= w_rd_acc;
               if (w_rd_acc) begin
                  r_s1_data <= w_s_data;
                  r_s1_err  <= w_s_err;
                  r_s1_perr <= w_s_perr;
               end
            end
         end

         assign w_o_valid = r_s1_valid;
         assign w_o_data  = r_s1_data;
         assign w_o_err   = r_s1_err;
         assign w_o_perr  = r_s1_perr;
      end else begin : g_lat1
         assign w_o_valid = w_rd_acc;
         assign w_o_data  = w_s_data;
         assign w_o_err   = w_s_err;
         assign w_o_perr  = w_s_perr;
      end
   endgenerate

   // Response payload only moves when a new response is loaded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_rsp_perr  <= 1'b0;
      end else if (!w_stall) begin
         r_rsp_valid <= w_o_valid;
         if (w_o_valid) begin
            r_rsp_rdata <= w_o_data;
            r_rsp_err   <= w_o_err;
            r_rsp_perr  <= w_o_perr;
         end
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign rsp_perr  = r_rsp_perr;
endmodule

// File: tb/tb_dmem_sync_hs.sv
// Bench for dmem_sync_hs: table-driven requests with a response scoreboard on a RD_LAT=1
// instance, plus hand sequences for stall, RD_LAT=2 ordering/reset and parity.
module tb_dmem_sync_hs;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
   logic [7:0]  req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic [1:0]  req_be = '0;
   logic        req_ready, rsp_valid, rsp_err, rsp_perr;
   logic [15:0] rsp_rdata;

   logic        rst2_n = 1'b0;
   logic        b_valid = 1'b0, b_we = 1'b0, b_rsp_ready = 1'b1;
   logic [7:0]  b_addr = '0;
   logic [15:0] b_wdata = '0;
   logic [1:0]  b_be = '0;
   logic        b_ready, b_rsp_valid, b_rsp_err, b_rsp_perr;
   logic [15:0] b_rsp_rdata;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [15:0] rdata;
      logic        err;
      logic        perr;
      int          due;
   } exp_t;
   exp_t q[$];

   typedef struct {
      logic        we;
      logic [7:0]  addr;
      logic [15:0] wdata;
      logic [1:0]  be;
      logic [15:0] exp_rdata;
      logic        exp_err;
   } vec_t;
   vec_t tbl[$];

   dmem_sync_hs #(.RD_LAT(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_perr(rsp_perr)
   );

   dmem_sync_hs #(.RD_LAT(2)) u_dut2 (
      .clk(clk), .rst_n(rst2_n), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
      .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be), .rsp_valid(b_rsp_valid),
      .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
      .rsp_perr(b_rsp_perr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard side: compare each consumed response against the oldest expectation
   always @(negedge clk) begin
      if (rst_n) begin
         if (q.size() > 0 && q[0].due == cyc && !rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL rsp_late: got rsp_valid 0, expected 1 (cycle %0d)", cyc);
         end
         if (rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_spurious: got rsp_valid 1, expected 0 (cycle %0d)", cyc);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
               chk("rsp_err", 32'(rsp_err), 32'(e.err));
               chk("rsp_perr", 32'(rsp_perr), 32'(e.perr));
            end
         end
      end
   end

   task automatic issue(input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                        input logic [1:0] be, input logic [15:0] erd, input logic eerr,
                        input logic eperr);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (req_ready) begin
            if (!we) q.push_back('{erd, eerr, eperr, cyc + 1});
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL req_accept_timeout: got req_ready 0, expected 1 (addr %h)", addr);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 50 && q.size() > 0; t++) @(negedge clk);
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 8; i++) tbl.push_back('{1'b0, 8'(i), 16'h0, 2'b00, 16'hFFFF, 1'b0});
      tbl.push_back('{1'b1, 8'd3,   16'h1234, 2'b11, 16'h0000, 1'b0});
      tbl.push_back('{1'b1, 8'd3,   16'hAB55, 2'b01, 16'h0000, 1'b0});
      tbl.push_back('{1'b0, 8'd3,   16'h0000, 2'b00, 16'h1255, 1'b0});
      tbl.push_back('{1'b0, 8'd8,   16'h0000, 2'b00, 16'h0000, 1'b1});
      tbl.push_back('{1'b1, 8'd9,   16'h55AA, 2'b11, 16'h0000, 1'b0});
      tbl.push_back('{1'b0, 8'd1,   16'h0000, 2'b00, 16'hFFFF, 1'b0});
      tbl.push_back('{1'b0, 8'd255, 16'h0000, 2'b00, 16'h0000, 1'b1});
      tbl.push_back('{1'b1, 8'd1,   16'h0000, 2'b00, 16'h0000, 1'b0});
      tbl.push_back('{1'b0, 8'd1,   16'h0000, 2'b00, 16'hFFFF, 1'b0});
      tbl.push_back('{1'b1, 8'd6,   16'h1234, 2'b10, 16'h0000, 1'b0});
      tbl.push_back('{1'b0, 8'd6,   16'h0000, 2'b00, 16'h12FF, 1'b0});
      tbl.push_back('{1'b1, 8'd2,   16'hBEEF, 2'b11, 16'h0000, 1'b0});
      tbl.push_back('{1'b0, 8'd2,   16'h0000, 2'b00, 16'hBEEF, 1'b0});

      repeat (2) @(posedge clk);
      #1;
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
      chk("reset_rsp_err", 32'(rsp_err), 32'd0);
      chk("reset_rsp_perr", 32'(rsp_perr), 32'd0);
      chk("reset_req_ready", 32'(req_ready), 32'd1);
      chk("reset2_rsp_valid", 32'(b_rsp_valid), 32'd0);
      rst_n  = 1'b1;
      rst2_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (tbl[i])
         issue(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].exp_rdata,
               tbl[i].exp_err, 1'b0);
      drain();

      // Backpressure: response held three cycles, a waiting request is refused, then
      // pop and accept happen on the same edge
      rsp_ready = 1'b0;
      issue(1'b0, 8'd2, 16'h0, 2'b00, 16'hBEEF, 1'b0, 1'b0);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 8'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("stall_req_ready", 32'(req_ready), 32'd0);
         chk("stall_rsp_rdata", 32'(rsp_rdata), 32'hBEEF);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      q.push_back('{16'hFFFF, 1'b0, 1'b0, cyc + 1});
      @(negedge clk);
      chk("pop_req_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      drain();

`ifdef DMEM_PARITY_EN
      u_dut.r_mem[5][0] = ~u_dut.r_mem[5][0];
      issue(1'b0, 8'd5, 16'h0, 2'b00, 16'hFFFE, 1'b0, 1'b1);
      issue(1'b1, 8'd5, 16'h0F0F, 2'b11, 16'h0, 1'b0, 1'b0);
      issue(1'b0, 8'd5, 16'h0, 2'b00, 16'h0F0F, 1'b0, 1'b0);
      drain();
`endif

      // RD_LAT=2 instance: distinct data, three back-to-back reads, reset mid-stream
      b_valid = 1'b1;
      b_we    = 1'b1;
      b_be    = 2'b11;
      b_addr  = 8'd0;
      b_wdata = 16'h1111;
      @(posedge clk);
      #1;
      b_addr  = 8'd1;
      b_wdata = 16'h2222;
      @(posedge clk);
      #1;
      b_addr  = 8'd2;
      b_wdata = 16'h3333;
      @(posedge clk);
      #1;
      b_we    = 1'b0;
      b_addr  = 8'd0;
      @(negedge clk);
      chk("lat2_c0_valid", 32'(b_rsp_valid), 32'd0);
      @(posedge clk);
      #1;
      b_addr = 8'd1;
      @(negedge clk);
      chk("lat2_c1_valid", 32'(b_rsp_valid), 32'd0);
      @(posedge clk);
      #1;
      b_addr = 8'd2;
      @(negedge clk);
      chk("lat2_c2_valid", 32'(b_rsp_valid), 32'd1);
      chk("lat2_c2_rdata", 32'(b_rsp_rdata), 32'h1111);
      @(posedge clk);
      #1;
      b_valid = 1'b0;
      @(negedge clk);
      chk("lat2_c3_valid", 32'(b_rsp_valid), 32'd1);
      chk("lat2_c3_rdata", 32'(b_rsp_rdata), 32'h2222);
      #1;
      rst2_n = 1'b0;
      #1;
      chk("lat2_rst_valid", 32'(b_rsp_valid), 32'd0);
      chk("lat2_rst_rdata", 32'(b_rsp_rdata), 32'd0);
      @(posedge clk);
      #1;
      rst2_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("lat2_post_rst_valid", 32'(b_rsp_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      b_valid = 1'b1;
      b_addr  = 8'd2;
      @(posedge clk);
      #1;
      b_valid = 1'b0;
      @(negedge clk);
      chk("lat2_persist_early", 32'(b_rsp_valid), 32'd0);
      @(negedge clk);
      chk("lat2_persist_valid", 32'(b_rsp_valid), 32'd1);
      chk("lat2_persist_rdata", 32'(b_rsp_rdata), 32'h3333);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
